// File: rtl/adder_pkg.sv
// adder_pkg: default adder geometry, group-count helper and the default-geometry stage record for the pipelined CLA adder
package adder_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_GROUP = 4;
  function automatic int num_groups(input int width, input int group);
    return (group < 1) ? 1 : width / group;
  endfunction
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] sum_lo;
    logic [DEFAULT_WIDTH-1:0] a_hi;
    logic [DEFAULT_WIDTH-1:0] b_hi;
    logic                     carry;
    logic                     msb_cin;
  } stage_t;
endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit lookahead cell; in a, b, c_in; out s (sum), g/p (group generate/propagate), c_out (group carry), c_msb (carry into top bit)
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p,
  output logic             c_out,
  output logic             c_msb
);
  logic [GROUP-1:0] gi, pi;
  logic [GROUP:0] gt, pt, c;
  logic term;
  assign gi = a & b;
  assign pi = a ^ b;
  always_comb begin
    gt = '0;
    pt = '0;
    term = 1'b0;
    pt[0] = 1'b1;
    for (int i = 1; i <= GROUP; i++) begin
      pt[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        term = gi[j];
        for (int k = j + 1; k < i; k++) term = term & pi[k];
        gt[i] = gt[i] | term;
        pt[i] = pt[i] & pi[j];
      end
    end
  end
  assign c = gt | (pt & {(GROUP + 1){c_in}});
  assign s = pi ^ c[GROUP-1:0];
  assign g = gt[GROUP];
  assign p = pt[GROUP];
  assign c_out = c[GROUP];
  assign c_msb = c[GROUP-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit lookahead adder, one register stage per GROUP-bit group, valid/ready both sides; in clk, rst, in_valid, be_add_number, add_number, Cin, out_ready; out in_ready, out_valid, sum, Cout, overflow
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] be_add_number,
  input  logic [WIDTH-1:0] add_number,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             overflow
);
  localparam int NG = num_groups(WIDTH, GROUP);
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic             carry;
    logic             msb_cin;
  } pipe_stage_t;
  if ((GROUP < 1) || (WIDTH % ((GROUP < 1) ? 1 : GROUP) != 0)) begin : g_bad_geometry
    $fatal(1, "pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
  end
  pipe_stage_t st [NG];
  logic advance;
  assign advance = !(out_valid && !out_ready);
  assign in_ready = advance;
  for (genvar k = 0; k < NG; k++) begin : g_stage
    pipe_stage_t prev, nxt;
    logic [GROUP-1:0] s;
    logic g, p, c_msb, unused_c_out;
    if (k == 0) begin : g_first
      assign prev = '{valid: in_valid, sum_lo: '0, a_hi: be_add_number, b_hi: add_number, carry: Cin, msb_cin: 1'b0};
    end else begin : g_next
      assign prev = st[k-1];
    end
    cla_group #(.GROUP(GROUP)) u_cla (
      .a    (prev.a_hi[k*GROUP +: GROUP]),
      .b    (prev.b_hi[k*GROUP +: GROUP]),
      .c_in (prev.carry),
      .s    (s),
      .g    (g),
      .p    (p),
      .c_out(unused_c_out),
      .c_msb(c_msb)
    );
    always_comb begin
      nxt = prev;
      nxt.sum_lo[k*GROUP +: GROUP] = s;
      nxt.carry = g | (p & prev.carry);
      nxt.msb_cin = c_msb;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) st[k] <= '0;
      else if (advance) st[k] <= nxt;
  end
  assign out_valid = st[NG-1].valid;
  assign sum = st[NG-1].sum_lo;
  assign Cout = st[NG-1].carry;
  assign overflow = st[NG-1].carry ^ st[NG-1].msb_cin;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and randomized checks of pipelined_cla_adder against an arithmetic queue model
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int pops16 = 0;
  logic iv, ir, ov, ordy, ci, co, of;
  logic [15:0] a, b, s;
  logic iv8, ir8, ov8, ordy8, ci8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic [17:0] q16 [$];
  logic [9:0] q8 [$];
  logic stall16 = 1'b0;
  logic stall8 = 1'b0;
  logic [18:0] held16 = '0;
  logic [10:0] held8 = '0;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .be_add_number(a), .add_number(b), .Cin(ci),
    .out_valid(ov), .out_ready(ordy), .sum(s), .Cout(co), .overflow(of)
  );
  pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .be_add_number(a8), .add_number(b8), .Cin(ci8),
    .out_valid(ov8), .out_ready(ordy8), .sum(s8), .Cout(co8), .overflow(of8)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [17:0] m16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    t = {1'b0, x} + {1'b0, y} + {16'b0, c};
    return {t[15:0], t[16], (x[15] == y[15]) && (t[15] != x[15])};
  endfunction

  function automatic logic [9:0] m8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    t = {1'b0, x} + {1'b0, y} + {8'b0, c};
    return {t[7:0], t[8], (x[7] == y[7]) && (t[7] != x[7])};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      q8.delete();
      stall16 = 1'b0;
      stall8 = 1'b0;
    end else begin
      check("in_ready16", 32'(ir), 32'(!(ov && !ordy)));
      check("in_ready8", 32'(ir8), 32'(!(ov8 && !ordy8)));
      if (stall16) check("hold16", 32'({ov, s, co, of}), 32'(held16));
      if (stall8) check("hold8", 32'({ov8, s8, co8, of8}), 32'(held8));
      if (ov && ordy) begin
        if (q16.size() == 0) check("extra16", 32'(1), 32'(0));
        else begin
          check("result16", 32'({s, co, of}), 32'(q16.pop_front()));
          pops16++;
        end
      end
      if (ov8 && ordy8) begin
        if (q8.size() == 0) check("extra8", 32'(1), 32'(0));
        else check("result8", 32'({s8, co8, of8}), 32'(q8.pop_front()));
      end
      if (iv && ir) q16.push_back(m16(a, b, ci));
      if (iv8 && ir8) q8.push_back(m8(a8, b8, ci8));
      stall16 = ov && !ordy;
      stall8 = ov8 && !ordy8;
      held16 = {ov, s, co, of};
      held8 = {ov8, s8, co8, of8};
    end
  end

  task automatic one16(input logic [15:0] x, input logic [15:0] y, input logic c,
                       input logic [15:0] es, input logic eco, input logic eov, input string nm);
    int n;
    a = x; b = y; ci = c; iv = 1'b1; ordy = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    n = 1;
    while (!ov && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(4));
    check({nm, "_result"}, 32'({s, co, of}), 32'({es, eco, eov}));
    @(posedge clk);
    #1;
  endtask

  task automatic one8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] es, input logic eco, input logic eov, input string nm);
    int n;
    a8 = x; b8 = y; ci8 = c; iv8 = 1'b1; ordy8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(2));
    check({nm, "_result"}, 32'({s8, co8, of8}), 32'({es, eco, eov}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    iv = 0; a = 0; b = 0; ci = 0; ordy = 1;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; ordy8 = 1;
    #1;
    check("rst_out16", 32'({ov, s, co, of}), 32'(0));
    check("rst_out8", 32'({ov8, s8, co8, of8}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("in_ready_after_rst", 32'(ir), 32'(1));
    check("model_pin_ovf", 32'(m16(16'h7FFF, 16'h0001, 1'b0)), 32'({16'h8000, 1'b0, 1'b1}));
    check("model_pin_cin", 32'(m16(16'hFFFF, 16'h0000, 1'b1)), 32'({16'h0000, 1'b1, 1'b0}));
    one16(16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, "add_0_1");
    one16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    one16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "cin_wrap");
    one16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    one16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    one8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "w8_cin");
    begin : stall_test
      int idx;
      int p0;
      logic acc;
      idx = 0;
      p0 = pops16;
      for (int cyc = 0; cyc < 16; cyc++) begin
        ordy = !(cyc >= 5 && cyc <= 7);
        iv = idx < 6;
        a = 16'(idx + 1);
        b = 16'h0010;
        ci = 1'b0;
        #1 check("stall_in_ready", 32'(ir), 32'(!(cyc >= 5 && cyc <= 7)));
        acc = iv && ir;
        @(posedge clk);
        if (acc) idx++;
        #1;
      end
      iv = 1'b0;
      ordy = 1'b1;
      check("stall_count", 32'(pops16 - p0), 32'(6));
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); iv = 1'b1; ordy = 1'b0;
      @(posedge clk);
      #1;
    end
    iv = 1'b0;
    check("pre_rst_out_valid", 32'(ov), 32'(1));
    rst = 1'b1;
    #1 check("rst_mid_out", 32'({ov, s, co, of}), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_quiet", 32'(ov), 32'(0));
      @(posedge clk);
      #1;
    end
    one16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "after_rst");
    fork
      for (int i = 0; i < 3000; i++) begin
        iv = $urandom_range(0, 3) != 0;
        a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        ci = 1'($urandom);
        ordy = $urandom_range(0, 3) != 0;
        @(posedge clk);
        #1;
      end
      for (int j = 0; j < 3000; j++) begin
        iv8 = $urandom_range(0, 3) != 0;
        a8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        b8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        ci8 = 1'($urandom);
        ordy8 = $urandom_range(0, 3) != 0;
        @(posedge clk);
        #1;
      end
    join
    iv = 1'b0; ordy = 1'b1; iv8 = 1'b0; ordy8 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain16", 32'(q16.size()), 32'(0));
    check("drain8", 32'(q8.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
